// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder / execution unit pair: opcodes,
// ARM condition codes, NZCV bit positions and FlagW bit meanings.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_CMP = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_LSR = 3'b101,
        OP_LSL = 3'b110,
        OP_RSV = 3'b111
    } alu_op_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW[1] enables the N,Z write; FlagW[0] enables the C,V write.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/alu_exec_unit_cond_check.sv
// Combinational ARM condition evaluation: Cond x NZCV -> pass/fail.
// Kept standalone so the PC-select logic can reuse it.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/logic, serial one-bit-per-cycle
// LSL/LSR, and ownership of the architectural NZCV register.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       FlagW,
    input  logic [3:0]       Cond,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [SHW-1:0]   Shamt,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CondEx,
    output logic [3:0]       Flags
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state, state_next;
    alu_op_e           op_in, op_q;
    logic [1:0]        flagw_q;
    logic              cond_pend, carry_q;
    logic [WIDTH-1:0]  work;
    logic [SHW-1:0]    count;
    logic              cond_now, is_shift;

    cond_check u_cond_check (.cond(Cond), .flags(Flags), .cond_ex(cond_now));

    assign op_in    = alu_op_e'(ALUControl);
    assign is_shift = (op_in == OP_LSL) || (op_in == OP_LSR);
    assign Busy     = (state == SHIFT);

    // Shared adder: SUB/CMP use A + ~B + 1 so C reads as "no borrow".
    logic             sub, carry_out, ovf;
    logic [WIDTH-1:0] b_eff, sum;

    assign sub   = (op_in == OP_SUB) || (op_in == OP_CMP);
    assign b_eff = sub ? ~SrcB : SrcB;
    assign {carry_out, sum} = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign ovf   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);

    logic             commit, cm_cond, cm_wr, cm_c, cm_v;
    logic [1:0]       cm_fw;
    logic [WIDTH-1:0] cm_res;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        cm_res     = '0;
        cm_c       = Flags[FLAG_C];
        cm_v       = Flags[FLAG_V];
        cm_cond    = cond_now;
        cm_fw      = FlagW;
        cm_wr      = 1'b0;
        unique case (state)
            IDLE: if (Start) begin
                if (is_shift) begin
                    state_next = SHIFT;
                end else begin
                    commit = 1'b1;
                    cm_wr  = (op_in != OP_RSV);
                    unique case (op_in)
                        OP_ADD, OP_SUB, OP_CMP: begin
                            cm_res = sum;
                            cm_c   = carry_out;
                            cm_v   = ovf;
                        end
                        OP_AND:  cm_res = SrcA & SrcB;
                        OP_OR:   cm_res = SrcA | SrcB;
                        default: cm_res = '0;
                    endcase
                end
            end
            SHIFT: if (count == '0) begin
                state_next = IDLE;
                commit     = 1'b1;
                cm_res     = work;
                cm_c       = carry_q;
                cm_cond    = cond_pend;
                cm_fw      = flagw_q;
                cm_wr      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            flagw_q   <= '0;
            cond_pend <= 1'b0;
            carry_q   <= 1'b0;
            work      <= '0;
            count     <= '0;
            Result    <= '0;
            CondEx    <= 1'b0;
            Flags     <= '0;
            Done      <= 1'b0;
        end else begin
            state <= state_next;
            Done  <= commit;
            if (state == IDLE && Start && is_shift) begin
                op_q      <= op_in;
                flagw_q   <= FlagW;
                cond_pend <= cond_now;
                // Seeded with old C so a zero-length shift leaves C untouched.
                carry_q   <= Flags[FLAG_C];
                work      <= SrcB;
                count     <= Shamt;
            end else if (state == SHIFT && count != '0) begin
                if (op_q == OP_LSL) begin
                    work    <= {work[WIDTH-2:0], 1'b0};
                    carry_q <= work[WIDTH-1];
                end else begin
                    work    <= {1'b0, work[WIDTH-1:1]};
                    carry_q <= work[0];
                end
                count <= count - 1'b1;
            end
            if (commit) begin
                Result <= cm_res;
                CondEx <= cm_cond;
                if (cm_wr && cm_cond && cm_fw[FW_NZ]) begin
                    Flags[FLAG_N] <= cm_res[WIDTH-1];
                    Flags[FLAG_Z] <= (cm_res == '0);
                end
                if (cm_wr && cm_cond && cm_fw[FW_CV]) begin
                    Flags[FLAG_C] <= cm_c;
                    Flags[FLAG_V] <= cm_v;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: an arithmetic reference model pushes
// expected completions; a negedge monitor pops them when Done is seen.
module tb_alu_exec_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [2:0]  ALUControl;
    logic [1:0]  FlagW;
    logic [3:0]  Cond;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  Shamt;
    logic        Busy, Done, CondEx;
    logic [31:0] Result;
    logic [3:0]  Flags;

    alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .ALUControl(ALUControl),
        .FlagW(FlagW), .Cond(Cond), .SrcA(SrcA), .SrcB(SrcB), .Shamt(Shamt),
        .Busy(Busy), .Done(Done), .Result(Result), .CondEx(CondEx), .Flags(Flags)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] res;
        logic        cex;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] mflags = 4'b0000;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drives one request and pushes the model's view of its completion.
    task automatic issue(input logic [2:0] op, input logic [1:0] fw, input logic [3:0] cd,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input bit hold);
        longint          sa, sb, sv;
        longint unsigned wide;
        logic [31:0]     res;
        bit              ok, wr, nc, nv;
        int              si;
        exp_t            e;
        @(posedge CLK); #1;
        Start = 1'b1; ALUControl = op; FlagW = fw; Cond = cd;
        SrcA = a; SrcB = b; Shamt = sh;
        ok = cond_ok(cd, mflags);
        sa = $signed(a); sb = $signed(b); si = int'(sh);
        res = '0; nc = mflags[1]; nv = mflags[0]; wr = 1'b1;
        case (op)
            3'd0: begin
                wide = longint'(a) + longint'(b);
                res = wide[31:0]; nc = wide[32];
                sv = sa + sb; nv = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            3'd1, 3'd2: begin
                res = a - b; nc = (a >= b);
                sv = sa - sb; nv = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: begin res = b >> sh; if (si != 0) nc = b[si-1]; end
            3'd6: begin res = b << sh; if (si != 0) nc = b[32-si]; end
            default: wr = 1'b0;
        endcase
        e.res = res; e.cex = ok;
        e.cyc = cyc + ((op == 3'd5 || op == 3'd6) ? si + 2 : 1);
        if (wr && ok && fw[1]) begin mflags[3] = res[31]; mflags[2] = (res == 0); end
        if (wr && ok && fw[0]) begin mflags[1] = nc; mflags[0] = nv; end
        e.flg = mflags;
        expq.push_back(e);
        if ((op == 3'd5 || op == 3'd6) && !hold) begin
            int n;
            @(posedge CLK); #1;
            // Stray request while busy: must be dropped, not queued.
            Start = ($urandom_range(0, 1) == 1);
            ALUControl = 3'($urandom_range(0, 4)); SrcA = $urandom; SrcB = $urandom;
            n = 0;
            while (Busy && n < 40) begin
                @(posedge CLK); #1; Start = 1'b0; n++;
            end
            Start = 1'b0;
            if (Busy) chk("busy_timeout", 32'(Busy), 32'd0);
        end
    endtask

    task automatic idle();
        @(posedge CLK); #1; Start = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RESET && Done) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got Done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("result", Result, e.res);
                chk("condex", 32'(CondEx), 32'(e.cex));
                chk("flags", 32'(Flags), 32'(e.flg));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; Start = 1'b0; ALUControl = '0; FlagW = '0; Cond = '0;
        SrcA = '0; SrcB = '0; Shamt = '0;
        #2;
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_condex", 32'(CondEx), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Directed cases.
        issue(3'd0, 2'b11, 4'b1110, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
        issue(3'd1, 2'b11, 4'b1110, 32'd5, 32'd5, 5'd0, 1'b0);
        issue(3'd2, 2'b11, 4'b0000, 32'd3, 32'd3, 5'd0, 1'b0);
        issue(3'd0, 2'b11, 4'b0001, 32'd1, 32'd1, 5'd0, 1'b0);
        issue(3'd7, 2'b11, 4'b1110, 32'hDEAD_BEEF, 32'h1234, 5'd0, 1'b0);
        issue(3'd0, 2'b11, 4'b1111, 32'd0, 32'd0, 5'd0, 1'b0);
        idle();
        issue(3'd6, 2'b11, 4'b1110, 32'h0, 32'h8000_0001, 5'd1, 1'b0);
        issue(3'd5, 2'b11, 4'b1110, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
        issue(3'd6, 2'b11, 4'b1110, 32'h0, 32'h0000_00F0, 5'd0, 1'b0);
        issue(3'd0, 2'b11, 4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        idle();

        // Reset in the middle of a long shift: no completion may appear.
        issue(3'd6, 2'b11, 4'b1110, 32'h0, 32'h0000_0003, 5'd20, 1'b1);
        idle();
        repeat (5) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("midrst_result", Result, 32'd0);
        chk("midrst_flags", 32'(Flags), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_condex", 32'(CondEx), 32'd0);
        expq.delete(expq.size() - 1);
        mflags = 4'b0000;
        @(posedge CLK); #1 RESET = 1'b0;
        issue(3'd3, 2'b10, 4'b1110, 32'h0000_00F0, 32'h0000_003C, 5'd0, 1'b0);
        idle();

        // Randomized mix, non-shift ops issued back to back.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 3'($urandom_range(0, 7));
            issue(op, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15)),
                  a, b, 5'($urandom_range(0, 31)), 1'b0);
        end
        idle();

        repeat (5) @(posedge CLK);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
